// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register as a 2-entry skid buffer with forwarding and branch taps
module ex_mem_pipe #(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_z,
  input  logic             in_zero,
  input  logic [WIDTH-1:0] in_rd2,
  input  logic [RW-1:0]    in_dst,
  input  logic [3:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_rd2,
  output logic [RW-1:0]    out_dst,
  output logic [3:0]       out_ctrl,
  output logic             fwd_valid,
  output logic [RW-1:0]    fwd_dst,
  output logic [WIDTH-1:0] fwd_data,
  output logic             br_taken,
  output logic [1:0]       occupancy
);
  localparam int PW = 2*WIDTH + RW + 5;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] head_q, skid_q, in_pl;
  logic          in_ready_q, in_fire, out_fire;
  assign in_pl     = {in_z, in_zero, in_rd2, in_dst, in_ctrl};
  assign {out_z, out_zero, out_rd2, out_dst, out_ctrl} = head_q;
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign fwd_valid = out_valid & out_ctrl[3] & ~out_ctrl[2] & (|out_dst);
  assign fwd_dst   = out_dst;
  assign fwd_data  = out_z;
  assign br_taken  = out_valid & out_ctrl[0] & out_zero;
  always_comb begin
    state_d = flush             ? EMPTY :
              state_q == EMPTY  ? (in_fire ? ONE : EMPTY) :
              state_q == ONE    ? ((in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE) :
                                  (out_fire ? ONE : FULL);
  end
  // Payload is only written on moves; pops and flushes just retire the valid state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != FULL;
      if (!flush) begin
        if (in_fire && (state_q == EMPTY || out_fire)) head_q <= in_pl;
        else if (state_q == FULL && out_fire) head_q <= skid_q;
        if (in_fire && !out_fire && state_q == ONE) skid_q <= in_pl;
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: randomized and directed checks of ex_mem_pipe against a queue-based model
module tb_ex_mem_pipe;
  localparam int W = 32;
  localparam int RW = 5;
  localparam int PW = 2*W + RW + 5;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_z = 0, in_rd2 = 0;
  logic in_zero = 0;
  logic [RW-1:0] in_dst = 0;
  logic [3:0] in_ctrl = 0;
  logic in_ready, out_valid, out_zero, fwd_valid, br_taken;
  logic [W-1:0] out_z, out_rd2, fwd_data;
  logic [RW-1:0] out_dst, fwd_dst;
  logic [3:0] out_ctrl;
  logic [1:0] occupancy;
  int checks = 0, failures = 0;
  logic [PW-1:0] q[$];
  logic [PW-1:0] m_last = '0;
  logic m_ready = 0;

  ex_mem_pipe #(.WIDTH(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_zero(in_zero), .in_rd2(in_rd2), .in_dst(in_dst), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_zero(out_zero),
    .out_rd2(out_rd2), .out_dst(out_dst), .out_ctrl(out_ctrl), .fwd_valid(fwd_valid),
    .fwd_dst(fwd_dst), .fwd_data(fwd_data), .br_taken(br_taken), .occupancy(occupancy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic v;
    logic [PW-1:0] h;
    logic [3:0] c;
    logic [RW-1:0] d;
    v = q.size() > 0;
    h = m_last;
    c = h[3:0];
    d = h[RW+3:4];
    chk("out_valid", PW'(out_valid), PW'(v));
    chk("in_ready", PW'(in_ready), PW'(m_ready));
    chk("occupancy", PW'(occupancy), PW'(q.size()));
    chk("head", {out_z, out_zero, out_rd2, out_dst, out_ctrl}, h);
    chk("fwd_valid", PW'(fwd_valid), PW'(v && c[3] && !c[2] && d != 0));
    chk("fwd_dst", PW'(fwd_dst), PW'(d));
    chk("fwd_data", PW'(fwd_data), PW'(h[PW-1 -: W]));
    chk("br_taken", PW'(br_taken), PW'(v && c[0] && h[PW-W-1]));
  endtask

  // Inputs are applied at the falling edge, the model advances at the rising edge.
  task automatic step(input logic rn, input logic fl, input logic iv, input logic ordy,
                      input logic [W-1:0] z, input logic zr, input logic [W-1:0] rd2,
                      input logic [RW-1:0] dst, input logic [3:0] ctrl);
    logic inf, outf;
    rst_n = rn; flush = fl; in_valid = iv; out_ready = ordy;
    in_z = z; in_zero = zr; in_rd2 = rd2; in_dst = dst; in_ctrl = ctrl;
    @(posedge clk);
    inf = iv && m_ready;
    outf = q.size() > 0 && ordy;
    if (!rn) begin
      q.delete(); m_ready = 0; m_last = '0;
    end else if (fl) begin
      q.delete(); m_ready = 1;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({z, zr, rd2, dst, ctrl});
      m_ready = q.size() < 2;
    end
    if (q.size() > 0) m_last = q[0];
    @(negedge clk);
    check_all();
  endtask

  task automatic push(input logic ordy, input logic [W-1:0] z, input logic zr,
                      input logic [RW-1:0] dst, input logic [3:0] ctrl);
    step(1, 0, 1, ordy, z, zr, 32'hA5A5_0000 ^ z, dst, ctrl);
  endtask

  task automatic idle(input logic ordy);
    step(1, 0, 0, ordy, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'hDEAD, 1, 32'hBEEF, 9, 4'hF);
    idle(1);
    chk("ready_after_release", PW'(in_ready), PW'(1));
    push(1, 32'h5, 0, 3, 4'b1000);
    chk("t1_z", PW'(out_z), PW'(32'h5));
    chk("t1_fwd", PW'({fwd_valid, fwd_dst}), PW'({1'b1, 5'd3}));
    idle(1);
    push(0, 32'h11, 0, 1, 4'b1000);
    push(0, 32'h22, 0, 2, 4'b1000);
    chk("t2_occ", PW'(occupancy), PW'(2));
    chk("t2_ready", PW'(in_ready), PW'(0));
    idle(0);
    chk("t2_hold", PW'(out_z), PW'(32'h11));
    idle(1);
    chk("t2_second", PW'(out_z), PW'(32'h22));
    idle(1);
    for (int i = 0; i < 16; i++) push(1, W'(i), 0, 5'(i), 4'b1000);
    idle(1);
    push(0, 32'h33, 0, 4, 4'b1000);
    push(0, 32'h44, 0, 5, 4'b1000);
    step(1, 1, 1, 0, 32'h99, 0, 0, 6, 4'b1000);
    chk("t4_flush", PW'({occupancy, out_valid, in_ready}), PW'({2'd0, 1'b0, 1'b1}));
    idle(1);
    chk("t4_gone", PW'(out_valid), PW'(0));
    push(1, 32'h0, 1, 0, 4'b0001);
    chk("t5_br", PW'(br_taken), PW'(1));
    push(1, 32'h7, 0, 7, 4'b1100);
    chk("t5_load", PW'(fwd_valid), PW'(0));
    push(1, 32'h8, 0, 0, 4'b1000);
    chk("t5_r0", PW'(fwd_valid), PW'(0));
    idle(1);
    push(0, 32'h55, 0, 8, 4'b1000);
    push(0, 32'h66, 1, 9, 4'b1001);
    step(0, 0, 1, 0, 32'h77, 0, 0, 1, 4'b1000);
    chk("t6_rst", {out_valid, in_ready, fwd_valid, br_taken, occupancy, out_z}, '0);
    idle(1);
    idle(1);
    chk("t6_no_stale", PW'(out_valid), PW'(0));
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0, 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom, 1'($urandom), $urandom,
           5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 4'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
